// File: rtl/encoder_type_1_if.sv
// Request/result bundle between a float producer and encoder_type_1.
// The encoder takes the slave side; whoever issues requests takes the master side.
interface encoder_type_1_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CODE_WIDTH = 8
);
  logic                  encode_start;
  logic [DATA_WIDTH-1:0] inp_value;
  logic                  busy;
  logic                  code_ready;
  logic [CODE_WIDTH-1:0] out_code;
  logic                  encode_error;

  modport master (
    output encode_start,
    output inp_value,
    input  busy,
    input  code_ready,
    input  out_code,
    input  encode_error
  );

  modport slave (
    input  encode_start,
    input  inp_value,
    output busy,
    output code_ready,
    output out_code,
    output encode_error
  );
endinterface

// File: rtl/encoder_type_1.sv
// Maps a single-precision float back to its 8-bit decoder_type_1 code.
// The search is sequential and exact, stepping through one table entry per clock.
module encoder_type_1 #(
  parameter int DATA_WIDTH  = 32,
  parameter int CODE_WIDTH  = 8,
  parameter int NUM_ENTRIES = 12
) (
  input  logic             clock,
  input  logic             reset,
  encoder_type_1_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] LAST_INDEX = 4'(NUM_ENTRIES - 1);

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_value;
  logic [3:0]            r_index;
  logic                  r_busy;
  logic                  r_codeReady;
  logic [CODE_WIDTH-1:0] r_outCode;
  logic                  r_encodeError;

  logic [DATA_WIDTH-1:0] w_tableValue;
  logic [5:0]            w_code;
  logic                  w_match;

  // Code 10 has no table entry, so the last two values skip to 11 and 12.
  always_comb begin
    w_tableValue = '0;
    w_code       = '0;
    case (r_index)
      4'd0:    begin w_tableValue = 32'h3F80_0000; w_code = 6'd0;  end
      4'd1:    begin w_tableValue = 32'h4000_0000; w_code = 6'd1;  end
      4'd2:    begin w_tableValue = 32'h4040_0000; w_code = 6'd2;  end
      4'd3:    begin w_tableValue = 32'h4080_0000; w_code = 6'd3;  end
      4'd4:    begin w_tableValue = 32'h40C0_0000; w_code = 6'd4;  end
      4'd5:    begin w_tableValue = 32'h4100_0000; w_code = 6'd5;  end
      4'd6:    begin w_tableValue = 32'h4140_0000; w_code = 6'd6;  end
      4'd7:    begin w_tableValue = 32'h4180_0000; w_code = 6'd7;  end
      4'd8:    begin w_tableValue = 32'h41C0_0000; w_code = 6'd8;  end
      4'd9:    begin w_tableValue = 32'h4200_0000; w_code = 6'd9;  end
      4'd10:   begin w_tableValue = 32'h4240_0000; w_code = 6'd11; end
      4'd11:   begin w_tableValue = 32'h4280_0000; w_code = 6'd12; end
      default: begin w_tableValue = '0;            w_code = 6'd0;  end
    endcase
  end

  assign w_match = (r_value == w_tableValue);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_value       <= '0;
      r_index       <= '0;
      r_busy        <= 1'b0;
      r_codeReady   <= 1'b0;
      r_outCode     <= '0;
      r_encodeError <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_codeReady <= 1'b0;
          r_busy      <= 1'b0;
          if (bus.encode_start) begin
            r_value       <= bus.inp_value;
            r_index       <= '0;
            r_outCode     <= '0;
            r_encodeError <= 1'b0;
            r_busy        <= 1'b1;
            r_state       <= SEARCH;
          end
        end
        SEARCH: begin
          if (w_match) begin
            r_outCode   <= {{(CODE_WIDTH-6){1'b0}}, w_code};
            r_codeReady <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= DONE;
          end else if (r_index == LAST_INDEX) begin
            r_outCode     <= '1;
            r_encodeError <= 1'b1;
            r_codeReady   <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= DONE;
          end else begin
            r_index <= r_index + 4'd1;
          end
        end
        DONE: begin
          r_codeReady <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
        default: begin
          r_state       <= IDLE;
          r_value       <= '0;
          r_index       <= '0;
          r_busy        <= 1'b0;
          r_codeReady   <= 1'b0;
          r_outCode     <= '0;
          r_encodeError <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy         = r_busy;
  assign bus.code_ready   = r_codeReady;
  assign bus.out_code     = r_outCode;
  assign bus.encode_error = r_encodeError;

endmodule

// File: tb/tb_encoder_type_1.sv
// Directed bench for encoder_type_1: table sweep, misses, reset mid-search,
// held start, and requests arriving during the result cycle.
module tb_encoder_type_1;

  logic clock;
  logic reset;
  int   assertCount;
  int   failCount;

  encoder_type_1_if bus ();

  encoder_type_1 dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Inverse of the code map, standing in for decoder_type_1 in loopback checks.
  function automatic logic [31:0] decodeModel(input logic [7:0] code);
    case (code)
      8'd0:    return 32'h3F80_0000;
      8'd1:    return 32'h4000_0000;
      8'd2:    return 32'h4040_0000;
      8'd3:    return 32'h4080_0000;
      8'd4:    return 32'h40C0_0000;
      8'd5:    return 32'h4100_0000;
      8'd6:    return 32'h4140_0000;
      8'd7:    return 32'h4180_0000;
      8'd8:    return 32'h41C0_0000;
      8'd9:    return 32'h4200_0000;
      8'd11:   return 32'h4240_0000;
      8'd12:   return 32'h4280_0000;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic startEncode(input logic [31:0] value);
    @(negedge clock);
    bus.encode_start = 1'b1;
    bus.inp_value    = value;
    @(negedge clock);
    bus.encode_start = 1'b0;
    bus.inp_value    = 32'hDEAD_BEEF;
    checkOutput("busyAfterAccept", 32'(bus.busy), 32'd1);
    checkOutput("codeClearedOnAccept", 32'(bus.out_code), 32'd0);
    checkOutput("errorClearedOnAccept", 32'(bus.encode_error), 32'd0);
  endtask

  task automatic waitResult(input logic [7:0] expCode, input logic expErr, input int expLatency);
    int cycles;
    cycles = 0;
    while (!bus.code_ready && cycles < 20) begin
      @(negedge clock);
      cycles++;
    end
    if (!bus.code_ready) begin
      checkOutput("resultTimeout", 32'(bus.code_ready), 32'd1);
    end else begin
      checkOutput("latency", 32'(cycles), 32'(expLatency));
      checkOutput("outCode", 32'(bus.out_code), 32'(expCode));
      checkOutput("encodeError", 32'(bus.encode_error), 32'(expErr));
      checkOutput("busyInDone", 32'(bus.busy), 32'd0);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] value, input logic [7:0] expCode, input logic expErr, input int expLatency);
    startEncode(value);
    waitResult(expCode, expErr, expLatency);
    if (!expErr) checkOutput("loopback", decodeModel(bus.out_code), value);
    @(negedge clock);
    checkOutput("pulseEnds", 32'(bus.code_ready), 32'd0);
    checkOutput("codeHoldsInIdle", 32'(bus.out_code), 32'(expCode));
  endtask

  logic [31:0] sweepValues [12] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                                    32'h40C0_0000, 32'h4100_0000, 32'h4140_0000, 32'h4180_0000,
                                    32'h41C0_0000, 32'h4200_0000, 32'h4240_0000, 32'h4280_0000};
  logic [7:0]  sweepCodes  [12] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd11, 8'd12};
  logic [31:0] missValues  [7]  = '{32'h40A0_0000, 32'hBF80_0000, 32'h0000_0000, 32'h8000_0000,
                                    32'h7FC0_0000, 32'h7F80_0000, 32'h0000_0001};

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pulses;
    int firstPulse;
    int secondPulse;
    assertCount      = 0;
    failCount        = 0;
    reset            = 1'b1;
    bus.encode_start = 1'b0;
    bus.inp_value    = '0;

    #3;
    checkOutput("resetBusy", 32'(bus.busy), 32'd0);
    checkOutput("resetReady", 32'(bus.code_ready), 32'd0);
    checkOutput("resetCode", 32'(bus.out_code), 32'd0);
    checkOutput("resetError", 32'(bus.encode_error), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Best case first, then every table entry in index order.
    applyStimulus(32'h3F80_0000, 8'h00, 1'b0, 1);
    for (int i = 0; i < 12; i++) applyStimulus(sweepValues[i], sweepCodes[i], 1'b0, i + 1);

    for (int i = 0; i < 7; i++) applyStimulus(missValues[i], 8'hFF, 1'b1, 12);

    // Reset lands in the third search cycle of 48.0.
    startEncode(32'h4240_0000);
    @(negedge clock);
    @(negedge clock);
    #1 reset = 1'b1;
    #1;
    checkOutput("midResetBusy", 32'(bus.busy), 32'd0);
    checkOutput("midResetReady", 32'(bus.code_ready), 32'd0);
    checkOutput("midResetCode", 32'(bus.out_code), 32'd0);
    checkOutput("midResetError", 32'(bus.encode_error), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clock);
      if (bus.code_ready) pulses++;
    end
    checkOutput("noPulseAfterReset", 32'(pulses), 32'd0);
    applyStimulus(32'h4240_0000, 8'd11, 1'b0, 11);

    // Start held high with 2.0; the value is disturbed during each search.
    @(negedge clock);
    bus.encode_start = 1'b1;
    bus.inp_value    = 32'h4000_0000;
    pulses      = 0;
    firstPulse  = -1;
    secondPulse = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (k == 1 || k == 5) bus.inp_value = 32'h4280_0000;
      if (bus.code_ready) begin
        pulses++;
        if (firstPulse < 0) firstPulse = k;
        else secondPulse = k;
        checkOutput("heldStartCode", 32'(bus.out_code), 32'h01);
        bus.inp_value = 32'h4000_0000;
      end
    end
    bus.encode_start = 1'b0;
    checkOutput("heldStartPulses", 32'(pulses), 32'd2);
    checkOutput("heldStartFirst", 32'(firstPulse), 32'd3);
    checkOutput("heldStartPeriod", 32'(secondPulse - firstPulse), 32'd4);
    @(negedge clock);
    @(negedge clock);

    // A request raised only during the result cycle must be dropped.
    startEncode(32'h4040_0000);
    waitResult(8'd2, 1'b0, 3);
    bus.encode_start = 1'b1;
    bus.inp_value    = 32'h3F80_0000;
    @(negedge clock);
    bus.encode_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checkOutput("doneStartNoBusy", 32'(bus.busy), 32'd0);
      checkOutput("doneStartNoReady", 32'(bus.code_ready), 32'd0);
      checkOutput("doneStartCodeHolds", 32'(bus.out_code), 32'd2);
    end
    applyStimulus(32'h4080_0000, 8'd3, 1'b0, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
